crc_stream_engine: RTL and testbench

//  Parametrised streaming CRC generator/checker for the SD host path. It succeeds the single-shot

---
 rtl/sd_crc_pkg.sv | 17 +
 rtl/crc_stream_engine_if.sv | 14 +
 rtl/crc_lfsr_step.sv | 27 ++
 rtl/crc_stream_engine.sv | 98 +++++++++
 tb/tb_crc_stream_engine.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_crc_pkg.sv
// Shared constants for the SD host CRC path: standard polynomials, widths
// and the engine state encoding.
package sd_crc_pkg;

    localparam int unsigned CRC7_LEN   = 7;
    localparam int unsigned CRC16_LEN  = 16;

    // Generator polynomials without the implicit x^CRC_LEN term
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Engine state encoding
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_DONE    = 2'd2;

endpackage

// File: rtl/crc_stream_engine_if.sv
// Valid/ready message stream into the CRC engine.
interface crc_stream_engine_if #(
    parameter int unsigned DATA_W = 1
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/crc_lfsr_step.sv
// Combinational CRC advance: DATA_W serial LFSR shifts in one cycle,
// MSB of data entering first.
module crc_lfsr_step #(
    parameter int unsigned CRC_LEN = 7,
    parameter int unsigned DATA_W  = 1
) (
    input  logic [CRC_LEN-1:0] crc_in,
    input  logic [CRC_LEN-1:0] poly,
    input  logic [DATA_W-1:0]  data,
    output logic [CRC_LEN-1:0] crc_out
);

    logic [CRC_LEN-1:0] acc;
    logic               fb;

    // Unrolled serial steps; a left shift keeps CRC_LEN=1 legal
    always_comb begin
        acc = crc_in;
        fb  = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb  = acc[CRC_LEN-1] ^ data[DATA_W-1-i];
            acc = (acc << 1) ^ (fb ? poly : '0);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker. GEN mode produces the CRC of the
// message; CHK mode expects the received CRC appended to the payload and
// flags a zero remainder. The engine holds only the FSM, the latched
// configuration, the CRC register and the beat counter.
module crc_stream_engine
    import sd_crc_pkg::*;
#(
    parameter int unsigned        CRC_LEN  = CRC7_LEN,
    parameter int unsigned        DATA_W   = 1,
    parameter logic [CRC_LEN-1:0] INIT_VAL = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CRC_LEN-1:0]  poly,
    input  logic                start,
    input  logic                chk_mode,
    input  logic                abort,
    crc_stream_engine_if.slave  strm,
    output logic                busy,
    output logic [CRC_LEN-1:0]  crc,
    output logic                crc_valid,
    output logic                crc_ok,
    output logic [CNT_W-1:0]    beat_cnt
);

    logic [1:0]         state_q;
    logic [CRC_LEN-1:0] poly_q;
    logic               chk_q;
    logic [CRC_LEN-1:0] crc_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [CRC_LEN-1:0] crc_next;
    logic               fire;

    crc_lfsr_step #(
        .CRC_LEN (CRC_LEN),
        .DATA_W  (DATA_W)
    ) u_step (
        .crc_in  (crc_q),
        .poly    (poly_q),
        .data    (strm.in_data),
        .crc_out (crc_next)
    );

    assign fire = strm.in_valid && (state_q == ST_RUN);

    // Handshake and status outputs decoded from state
    always_comb begin
        strm.in_ready = (state_q == ST_RUN);
        busy          = (state_q == ST_RUN);
        crc_valid     = (state_q == ST_DONE);
        crc_ok        = (state_q == ST_DONE) && chk_q && (crc_q == '0);
        crc           = crc_q;
        beat_cnt      = beat_cnt_q;
    end

    // FSM, configuration latch, CRC register and saturating beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            poly_q     <= '0;
            chk_q      <= 1'b0;
            crc_q      <= INIT_VAL;
            beat_cnt_q <= '0;
        end else if (abort) begin
            // abort keeps the CRC register but invalidates the result
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        poly_q     <= poly;
                        chk_q      <= chk_mode;
                        crc_q      <= INIT_VAL;
                        beat_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        crc_q <= crc_next;
                        if (beat_cnt_q != '1) begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                        if (strm.in_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized self-checking bench for crc_stream_engine. Two byte-wide
// engines (CRC16 with an 8-bit counter, CRC7) share one stream; a bit-serial
// CRC16 engine runs separately. Expected CRCs come from polynomial long
// division of the augmented message.
module tb_crc_stream_engine;
    import sd_crc_pkg::*;

    logic clk = 1'b0;
    logic reset, start, abort, chk_mode;
    logic [15:0] poly_a;
    logic [6:0]  poly_b;
    logic        v8, l8;
    logic [7:0]  d8;

    logic        start_c, abort_c, chk_c, v1, l1;
    logic [0:0]  d1;
    logic [15:0] poly_c;

    logic        busy_a, valid_a, ok_a, busy_b, valid_b, ok_b, busy_c, valid_c, ok_c;
    logic [15:0] crc_a, crc_c, cnt_b, cnt_c;
    logic [6:0]  crc_b;
    logic [7:0]  cnt_a;

    int n_checks = 0;
    int n_errors = 0;

    crc_stream_engine_if #(.DATA_W(8)) if_a ();
    crc_stream_engine_if #(.DATA_W(8)) if_b ();
    crc_stream_engine_if #(.DATA_W(1)) if_c ();

    assign if_a.in_valid = v8;
    assign if_a.in_data  = d8;
    assign if_a.in_last  = l8;
    assign if_b.in_valid = v8;
    assign if_b.in_data  = d8;
    assign if_b.in_last  = l8;
    assign if_c.in_valid = v1;
    assign if_c.in_data  = d1;
    assign if_c.in_last  = l1;

    crc_stream_engine #(.CRC_LEN(16), .DATA_W(8), .INIT_VAL(16'h0000), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .poly(poly_a), .start(start), .chk_mode(chk_mode),
        .abort(abort), .strm(if_a.slave), .busy(busy_a), .crc(crc_a),
        .crc_valid(valid_a), .crc_ok(ok_a), .beat_cnt(cnt_a));

    crc_stream_engine #(.CRC_LEN(7), .DATA_W(8), .INIT_VAL(7'h00), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .poly(poly_b), .start(start), .chk_mode(chk_mode),
        .abort(abort), .strm(if_b.slave), .busy(busy_b), .crc(crc_b),
        .crc_valid(valid_b), .crc_ok(ok_b), .beat_cnt(cnt_b));

    crc_stream_engine #(.CRC_LEN(16), .DATA_W(1), .INIT_VAL(16'h0000), .CNT_W(16)) crc_stream_engine (
        .clk(clk), .reset(reset), .poly(poly_c), .start(start_c), .chk_mode(chk_c),
        .abort(abort_c), .strm(if_c.slave), .busy(busy_c), .crc(crc_c),
        .crc_valid(valid_c), .crc_ok(ok_c), .beat_cnt(cnt_c));

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^len divided by x^len + poly
    function automatic logic [31:0] model_crc(input byte unsigned m[$], input int len,
                                              input logic [31:0] poly);
        bit b[$];
        logic [31:0] r;
        int n;
        foreach (m[i]) for (int k = 7; k >= 0; k--) b.push_back(m[i][k]);
        for (int k = 0; k < len; k++) b.push_back(1'b0);
        n = b.size();
        for (int i = 0; i < n - len; i++) begin
            if (b[i]) begin
                b[i] = 1'b0;
                for (int k = 0; k < len; k++) b[i+1+k] ^= poly[len-1-k];
            end
        end
        r = '0;
        for (int k = 0; k < len; k++) r = (r << 1) | 32'(b[n-len+k]);
        return r;
    endfunction

    function automatic void take(input byte unsigned m[$], input int lo, input int hi,
                                 output byte unsigned part[$]);
        part = {};
        for (int i = lo; i <= hi; i++) part.push_back(m[i]);
    endfunction

    task automatic do_start(input logic mode);
        @(negedge clk);
        poly_a = CRC16_POLY;
        poly_b = CRC7_POLY;
        start = 1'b1;
        chk_mode = mode;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy_a), 32'd1);
    endtask

    // Present beats MSB-first; returns with the final beat consumed
    task automatic send_beats(input byte unsigned m[$], input int gap, input bit mark_last,
                              output int cycles);
        int idx = 0;
        cycles = 0;
        while (idx < m.size() && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (gap > 0 && $urandom_range(99) < gap) begin
                v8 = 1'b0;
            end else begin
                v8 = 1'b1;
                d8 = m[idx];
                l8 = mark_last && (idx == m.size() - 1);
                if (if_a.in_ready) idx++;
            end
        end
        check("send_timeout", 32'(idx), 32'(m.size()));
        @(negedge clk);
        v8 = 1'b0;
        l8 = 1'b0;
    endtask

    task automatic run_msg(input byte unsigned m[$], input logic mode, input int gap);
        int cyc, n;
        logic [31:0] e16, e7;
        do_start(mode);
        // configuration inputs wander mid-message; latched copies must be used
        poly_a = 16'($urandom);
        poly_b = 7'($urandom);
        chk_mode = ~mode;
        send_beats(m, gap, 1'b1, cyc);
        n = m.size();
        if (gap == 0) check("no_bubble", 32'(cyc), 32'(n));
        e16 = model_crc(m, 16, 32'(CRC16_POLY));
        e7  = model_crc(m, 7, 32'(CRC7_POLY));
        check("crc16", 32'(crc_a), e16);
        check("crc7", 32'(crc_b), e7);
        check("valid_a", 32'(valid_a), 32'd1);
        check("valid_b", 32'(valid_b), 32'd1);
        check("ok_a", 32'(ok_a), 32'(mode && e16 == 0));
        check("ok_b", 32'(ok_b), 32'(mode && e7 == 0));
        check("cnt_a", 32'(cnt_a), (n > 255) ? 32'd255 : 32'(n));
        check("cnt_b", 32'(cnt_b), 32'(n));
        check("done_ready", 32'(if_a.in_ready), 32'd0);
    endtask

    task automatic run_bits(input byte unsigned m[$], input int gap);
        bit b[$];
        int idx = 0, cyc = 0;
        foreach (m[i]) for (int k = 7; k >= 0; k--) b.push_back(m[i][k]);
        @(negedge clk);
        poly_c = CRC16_POLY;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        while (idx < b.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (gap > 0 && $urandom_range(99) < gap) begin
                v1 = 1'b0;
            end else begin
                v1 = 1'b1;
                d1 = b[idx];
                l1 = (idx == b.size() - 1);
                if (if_c.in_ready) idx++;
            end
        end
        check("bits_timeout", 32'(idx), 32'(b.size()));
        @(negedge clk);
        v1 = 1'b0;
        l1 = 1'b0;
        check("c_crc", 32'(crc_c), model_crc(m, 16, 32'(CRC16_POLY)));
        check("c_valid", 32'(valid_c), 32'd1);
        check("c_cnt", 32'(cnt_c), 32'(b.size()));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(if_a.in_ready), 32'd0);
        check({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
        check({tag, "_crc_a"}, 32'(crc_a), 32'd0);
        check({tag, "_crc_b"}, 32'(crc_b), 32'd0);
        check({tag, "_valid"}, 32'({valid_a, valid_b}), 32'd0);
        check({tag, "_ok"}, 32'({ok_a, ok_b}), 32'd0);
        check({tag, "_cnt"}, 32'({cnt_a, cnt_b}), 32'd0);
    endtask

    initial begin
        byte unsigned m1[$], m2[$], m3[$], m3c[$], mr[$], part[$];
        int cyc;

        m1 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        m2 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 512; i++) m3.push_back(8'hFF);

        reset = 1'b1; start = 1'b0; abort = 1'b0; chk_mode = 1'b0;
        poly_a = CRC16_POLY; poly_b = CRC7_POLY; v8 = 1'b0; l8 = 1'b0; d8 = '0;
        start_c = 1'b0; abort_c = 1'b0; chk_c = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = '0;
        poly_c = CRC16_POLY;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst");
        check("rst_c_crc", 32'(crc_c), 32'd0);

        // in_valid while IDLE is not consumed
        v8 = 1'b1; d8 = 8'hAA; l8 = 1'b1;
        repeat (3) @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
        check("idle_cnt", 32'(cnt_a), 32'd0);
        check("idle_valid", 32'(valid_a), 32'd0);

        // CRC7 reference message
        run_msg(m1, 1'b0, 0);
        check("c1_crc7", 32'(crc_b), 32'h4A);
        check("c1_cnt", 32'(cnt_b), 32'd5);

        // in_valid while DONE leaves the result untouched
        v8 = 1'b1; d8 = 8'h55; l8 = 1'b1;
        repeat (3) @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
        check("done_hold_crc", 32'(crc_b), 32'h4A);
        check("done_hold_valid", 32'(valid_b), 32'd1);
        check("done_hold_cnt", 32'(cnt_b), 32'd5);

        // CRC16 check string, byte and bit-serial
        run_msg(m2, 1'b0, 0);
        check("c2_crc16", 32'(crc_a), 32'h31C3);
        run_bits(m2, 0);
        check("c2_serial", 32'(crc_c), 32'h31C3);

        // long message, counter saturation, CHK mode
        run_msg(m3, 1'b0, 0);
        check("c3_crc16", 32'(crc_a), 32'h7FA1);
        check("c3_sat", 32'(cnt_a), 32'd255);
        m3c = m3;
        m3c.push_back(8'h7F);
        m3c.push_back(8'hA1);
        run_msg(m3c, 1'b1, 0);
        check("c3_chk_crc", 32'(crc_a), 32'd0);
        check("c3_chk_ok", 32'(ok_a), 32'd1);
        m3c[100] = m3c[100] ^ 8'h04;
        run_msg(m3c, 1'b1, 0);
        check("c3_bad_ok", 32'(ok_a), 32'd0);

        // gaps on the stream
        repeat (3) begin
            run_msg(m2, 1'b0, 30);
            check("c4_crc16", 32'(crc_a), 32'h31C3);
        end
        repeat (8) begin
            mr = {};
            repeat ($urandom_range(40, 1)) mr.push_back(8'($urandom));
            run_msg(mr, 1'($urandom), 30);
        end
        mr = {};
        repeat ($urandom_range(12, 1)) mr.push_back(8'($urandom));
        run_bits(mr, 30);

        // abort mid-message then a clean restart
        do_start(1'b0);
        take(m1, 0, 2, part);
        send_beats(part, 0, 1'b0, cyc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy_b), 32'd0);
        check("abort_valid", 32'(valid_b), 32'd0);
        check("abort_cnt", 32'(cnt_b), 32'd0);
        run_msg(m1, 1'b0, 0);
        check("c5_crc7", 32'(crc_b), 32'h4A);

        // start during RUN is ignored
        do_start(1'b0);
        take(m1, 0, 1, part);
        send_beats(part, 0, 1'b0, cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_start_cnt", 32'(cnt_b), 32'd2);
        take(m1, 2, 4, part);
        send_beats(part, 0, 1'b1, cyc);
        check("c5_restart_crc7", 32'(crc_b), 32'h4A);
        check("c5_restart_cnt", 32'(cnt_b), 32'd5);

        // one-cycle reset mid-message
        do_start(1'b0);
        take(m2, 0, 3, part);
        send_beats(part, 0, 1'b0, cyc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midrst");

        // start and abort together from DONE
        run_msg(m1, 1'b0, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy_b), 32'd0);
        check("sa_valid", 32'(valid_b), 32'd0);
        check("sa_cnt", 32'(cnt_b), 32'd0);
        @(negedge clk);
        check("sa_idle", 32'({busy_a, valid_a}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
